// File: rtl/ped_walk_ctrl.sv
// Pedestrian crossing controller slaved to the vehicle light sequence.
// Accepts a debounced push-button request, grants WALK only on a fresh
// red onset, flashes DONT_WALK during clearance and latches illegal codes.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no request being served, DONT_WALK steady
// S_WAIT_RED | request latched, waiting for the next red onset
// S_WALK     | WALK lamp on for WALK_TIME cycles
// S_CLEAR    | DONT_WALK flashing, countdown CLEAR_TIME..1
// S_FAULT    | two consecutive illegal light codes seen; left only by rst
module ped_walk_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int WALK_TIME    = 6,
  parameter int CLEAR_TIME   = 3,
  parameter int FLASH_DIV    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_in,
  input  logic       btn,
  output logic       walk,
  output logic       dont_walk,
  output logic [3:0] countdown,
  output logic       req_pending,
  output logic       fault
);

  localparam int TW = $clog2(WALK_TIME + CLEAR_TIME + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_GREEN  = 3'b010;
  localparam logic [2:0] LT_YELLOW = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RED = 3'd1,
    S_WALK     = 3'd2,
    S_CLEAR    = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [FW-1:0]   flash_q, flash_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic            deb_q, deb_d;
  logic            deb_prev_q, deb_prev_d;
  logic [2:0]      prev_light_q, prev_light_d;
  logic            illegal_q, illegal_d;
  logic            walk_q, walk_d;
  logic            dont_walk_q, dont_walk_d;
  logic [3:0]      countdown_q, countdown_d;
  logic            req_q, req_d;
  logic            fault_q, fault_d;

  logic is_red, illegal, red_onset, deb_rise, entering;

  assign is_red    = (light_in == LT_RED);
  assign illegal   = (light_in != LT_RED) && (light_in != LT_GREEN) && (light_in != LT_YELLOW);
  assign red_onset = is_red && (prev_light_q != LT_RED);
  assign deb_rise  = deb_q && !deb_prev_q;
  assign entering  = (state_d != state_q);

  // Button synchronizer/debouncer and light-code history.
  always_comb begin
    sync1_d      = btn;
    sync2_d      = sync1_q;
    deb_cnt_d    = '0;
    deb_d        = 1'b0;
    if (sync2_q) begin
      deb_cnt_d = (deb_cnt_q == DW'(DEBOUNCE_CYC)) ? deb_cnt_q : deb_cnt_q + DW'(1);
      deb_d     = (deb_cnt_d == DW'(DEBOUNCE_CYC));
    end
    deb_prev_d   = deb_q;
    prev_light_d = light_in;
    illegal_d    = illegal;
  end

  // Next-state selection, timers and registered lamp outputs.
  always_comb begin
    state_d = state_q;
    if (state_q != S_FAULT && illegal && illegal_q) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE:     if (req_q) state_d = S_WAIT_RED;
        S_WAIT_RED: if (red_onset) state_d = S_WALK;
        S_WALK: begin
          if (!is_red)                 state_d = S_IDLE;
          else if (timer_q == TW'(1))  state_d = S_CLEAR;
        end
        S_CLEAR: begin
          if (!is_red || timer_q == TW'(1)) state_d = S_IDLE;
        end
        S_FAULT:    state_d = S_FAULT;
        default:    state_d = S_IDLE;
      endcase
    end

    // Down-counter reloads on every state entry and parks at zero.
    timer_d = timer_q;
    if (entering) begin
      if (state_d == S_WALK)       timer_d = TW'(WALK_TIME);
      else if (state_d == S_CLEAR) timer_d = TW'(CLEAR_TIME);
      else                         timer_d = '0;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end

    // Flash divider: lamp starts lit, toggles every FLASH_DIV cycles.
    flash_d = flash_q;
    if (state_d == S_CLEAR || state_d == S_FAULT) begin
      if (entering) begin
        dont_walk_d = 1'b1;
        flash_d     = FW'(FLASH_DIV - 1);
      end else if (flash_q == '0) begin
        dont_walk_d = !dont_walk_q;
        flash_d     = FW'(FLASH_DIV - 1);
      end else begin
        dont_walk_d = dont_walk_q;
        flash_d     = flash_q - FW'(1);
      end
    end else begin
      dont_walk_d = (state_d != S_WALK);
    end

    walk_d      = (state_d == S_WALK);
    countdown_d = (state_d == S_CLEAR) ? 4'(timer_d) : 4'd0;
    fault_d     = (state_d == S_FAULT);

    // A press arriving on the WALK-entry edge is kept rather than lost.
    if (state_d == S_FAULT)                 req_d = 1'b0;
    else if (deb_rise)                      req_d = 1'b1;
    else if (entering && state_d == S_WALK) req_d = 1'b0;
    else                                    req_d = req_q;
  end

  // All state held in flops with asynchronous reset to safe lamp values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      flash_q      <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      deb_cnt_q    <= '0;
      deb_q        <= 1'b0;
      deb_prev_q   <= 1'b0;
      prev_light_q <= LT_RED;
      illegal_q    <= 1'b0;
      walk_q       <= 1'b0;
      dont_walk_q  <= 1'b1;
      countdown_q  <= 4'd0;
      req_q        <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      flash_q      <= flash_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_cnt_q    <= deb_cnt_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_prev_d;
      prev_light_q <= prev_light_d;
      illegal_q    <= illegal_d;
      walk_q       <= walk_d;
      dont_walk_q  <= dont_walk_d;
      countdown_q  <= countdown_d;
      req_q        <= req_d;
      fault_q      <= fault_d;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign countdown   = countdown_q;
  assign req_pending = req_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ped_walk_ctrl.sv
// Bench for ped_walk_ctrl: directed scenarios plus randomized light/button
// traffic checked against a phase/elapsed-time reference model.
module tb_ped_walk_ctrl;

  localparam int DEB     = 4;
  localparam int WALK_T  = 6;
  localparam int CLEAR_T = 3;
  localparam int FLASH   = 1;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_WALK  = 2;
  localparam int M_CLEAR = 3;
  localparam int M_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] light_in;
  logic       btn;
  logic       walk, dont_walk, req_pending, fault;
  logic [3:0] countdown;
  logic [7:0] dut_v;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  int         m_mode, m_el, m_run;
  bit         m_req, m_fault, m_ill_prev;
  bit [2:0]   m_h;
  logic [2:0] m_prev;

  logic [5:0] seq_exp [10];
  logic [2:0] bad_codes [5];

  ped_walk_ctrl #(
    .DEBOUNCE_CYC(DEB), .WALK_TIME(WALK_T), .CLEAR_TIME(CLEAR_T), .FLASH_DIV(FLASH)
  ) dut (
    .clk(clk), .rst(rst), .light_in(light_in), .btn(btn),
    .walk(walk), .dont_walk(dont_walk), .countdown(countdown),
    .req_pending(req_pending), .fault(fault)
  );

  always #5 clk = ~clk;

  assign dut_v = {walk, dont_walk, countdown, req_pending, fault};

  task automatic model_reset();
    m_mode = M_IDLE; m_el = 0; m_run = 0; m_h = '0;
    m_req = 0; m_fault = 0; m_ill_prev = 0; m_prev = 3'b100;
  endtask

  // One clock edge of the reference: a press is accepted three edges after
  // the raw button has been sampled high DEB times in a row.
  task automatic model_edge(input logic [2:0] l, input logic b);
    bit press, ill, red, onset;
    int nm;
    press  = m_h[2];
    m_h[2] = m_h[1];
    m_h[1] = m_h[0];
    m_run  = b ? m_run + 1 : 0;
    m_h[0] = (m_run == DEB);
    ill   = !(l == 3'b100 || l == 3'b010 || l == 3'b001);
    red   = (l == 3'b100);
    onset = red && (m_prev != 3'b100);
    nm = m_mode;
    if (m_mode == M_FAULT) nm = M_FAULT;
    else if (ill && m_ill_prev) nm = M_FAULT;
    else begin
      case (m_mode)
        M_IDLE:  if (m_req) nm = M_WAIT;
        M_WAIT:  if (onset) nm = M_WALK;
        M_WALK:  if (!red) nm = M_IDLE; else if (m_el == WALK_T - 1) nm = M_CLEAR;
        M_CLEAR: if (!red || m_el == CLEAR_T - 1) nm = M_IDLE;
        default: nm = M_IDLE;
      endcase
    end
    if (nm == M_FAULT) begin m_req = 0; m_fault = 1; end
    else if (press) m_req = 1;
    else if (nm == M_WALK && m_mode != M_WALK) m_req = 0;
    m_el   = (nm == m_mode) ? m_el + 1 : 0;
    m_mode = nm;
    m_prev = l;
    m_ill_prev = ill;
  endtask

  function automatic logic [7:0] m_exp();
    logic w, dw;
    logic [3:0] cd;
    w  = (m_mode == M_WALK);
    cd = (m_mode == M_CLEAR) ? 4'(CLEAR_T - m_el) : 4'd0;
    if (m_mode == M_CLEAR || m_mode == M_FAULT) dw = ((m_el / FLASH) % 2) == 0;
    else dw = (m_mode != M_WALK);
    return {w, dw, cd, m_req, m_fault};
  endfunction

  task automatic step(input logic [2:0] l, input logic b);
    @(negedge clk);
    light_in = l;
    btn      = b;
    @(posedge clk);
    model_edge(l, b);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; light_in = 3'b100; btn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; light_in = 3'b010; btn = 1'b1;
    #1;
    tests_run++;
    if (dut_v !== 8'b0100_0000) begin
      tests_failed++;
      $display("FAIL reset_async: got %b want %b", dut_v, 8'b0100_0000);
    end
    @(posedge clk); @(posedge clk); #1;
    tests_run++;
    if (dut_v !== 8'b0100_0000) begin
      tests_failed++;
      $display("FAIL reset_held: got %b want %b", dut_v, 8'b0100_0000);
    end
    #1 rst = 1'b0; btn = 1'b0;
    model_reset();
    step(3'b010, 1'b0);
    tests_run++;
    if (dut_v !== m_exp()) begin
      tests_failed++;
      $display("FAIL reset_release: got %b want %b", dut_v, m_exp());
    end
  endtask

  task automatic test_request_service();
    int first_req = -1;
    for (int i = 1; i <= 10; i++) begin
      step(3'b010, 1'b1);
      if (req_pending === 1'b1 && first_req < 0) first_req = i;
      tests_run++;
      if (dut_v !== m_exp()) begin
        tests_failed++;
        $display("FAIL svc_press cyc %0d: got %b want %b", i, dut_v, m_exp());
      end
    end
    tests_run++;
    if (first_req != DEB + 3) begin
      tests_failed++;
      $display("FAIL svc_req_latency: got %0d want %0d", first_req, DEB + 3);
    end
    step(3'b010, 1'b0);
    step(3'b010, 1'b0);
    seq_exp = '{6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000,
                6'b010011, 6'b000010, 6'b010001, 6'b010000};
    for (int k = 0; k < 10; k++) begin
      step(3'b100, 1'b0);
      tests_run++;
      if ({walk, dont_walk, countdown} !== seq_exp[k]) begin
        tests_failed++;
        $display("FAIL svc_seq cyc %0d: got %b want %b", k, {walk, dont_walk, countdown}, seq_exp[k]);
      end
      if (k == 0) begin
        tests_run++;
        if (req_pending !== 1'b0) begin
          tests_failed++;
          $display("FAIL svc_req_clear: got %b want 0", req_pending);
        end
      end
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 4; j++) begin
        step(3'b010, (j < 3) ? 1'b1 : 1'b0);
        tests_run++;
        if (req_pending !== 1'b0) begin
          tests_failed++;
          $display("FAIL bounce r%0d j%0d: got %b want 0", r, j, req_pending);
        end
      end
    end
    for (int j = 0; j < 4; j++) step(3'b010, 1'b0);
  endtask

  task automatic test_mid_red();
    step(3'b100, 1'b0);
    step(3'b100, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(3'b100, (i < 8) ? 1'b1 : 1'b0);
      tests_run++;
      if (walk !== 1'b0) begin
        tests_failed++;
        $display("FAIL midred_hold cyc %0d: got walk=%b want 0", i, walk);
      end
    end
    tests_run++;
    if (req_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL midred_req: got %b want 1", req_pending);
    end
    for (int i = 0; i < 5; i++) begin
      step((i < 3) ? 3'b010 : 3'b001, 1'b0);
      tests_run++;
      if (walk !== 1'b0) begin
        tests_failed++;
        $display("FAIL midred_gy cyc %0d: got walk=%b want 0", i, walk);
      end
    end
    step(3'b100, 1'b0);
    tests_run++;
    if (walk !== 1'b1) begin
      tests_failed++;
      $display("FAIL midred_new_red: got walk=%b want 1", walk);
    end
    for (int i = 0; i < 12; i++) begin
      step(3'b100, 1'b0);
      tests_run++;
      if (dut_v !== m_exp()) begin
        tests_failed++;
        $display("FAIL midred_tail cyc %0d: got %b want %b", i, dut_v, m_exp());
      end
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 10; i++) step(3'b010, (i < 8) ? 1'b1 : 1'b0);
    for (int i = 0; i < 4; i++) step(3'b100, 1'b0);
    tests_run++;
    if (walk !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_pre: got walk=%b want 1", walk);
    end
    step(3'b010, 1'b0);
    tests_run++;
    if ({walk, dont_walk, countdown} !== 6'b010000) begin
      tests_failed++;
      $display("FAIL abort_outputs: got %b want %b", {walk, dont_walk, countdown}, 6'b010000);
    end
    for (int i = 0; i < 3; i++) begin
      step(3'b010, 1'b0);
      tests_run++;
      if (dut_v !== m_exp()) begin
        tests_failed++;
        $display("FAIL abort_after cyc %0d: got %b want %b", i, dut_v, m_exp());
      end
    end
  endtask

  task automatic test_fault();
    logic prev_dw;
    logic [2:0] l;
    do_reset();
    step(3'b010, 1'b0);
    step(3'b011, 1'b0);
    step(3'b010, 1'b0);
    tests_run++;
    if (fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_single: got %b want 0", fault);
    end
    step(3'b110, 1'b0);
    tests_run++;
    if (fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_first_bad: got %b want 0", fault);
    end
    step(3'b110, 1'b0);
    tests_run++;
    if (fault !== 1'b1) begin
      tests_failed++;
      $display("FAIL fault_set: got %b want 1", fault);
    end
    prev_dw = dont_walk;
    for (int i = 0; i < 9; i++) begin
      l = (i % 3 == 0) ? 3'b010 : (i % 3 == 1) ? 3'b001 : 3'b100;
      step(l, 1'b1);
      tests_run++;
      if ({fault, walk, countdown, req_pending} !== 7'b1000000 || dont_walk !== !prev_dw) begin
        tests_failed++;
        $display("FAIL fault_hold cyc %0d: got f=%b w=%b cd=%0d rq=%b dw=%b want f=1 w=0 cd=0 rq=0 dw=%b",
                 i, fault, walk, countdown, req_pending, dont_walk, !prev_dw);
      end
      prev_dw = dont_walk;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 10; i++) step(3'b010, (i < 8) ? 1'b1 : 1'b0);
    step(3'b100, 1'b0);
    step(3'b100, 1'b0);
    tests_run++;
    if (walk !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: got walk=%b want 1", walk);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (dut_v !== 8'b0100_0000) begin
      tests_failed++;
      $display("FAIL areset_drop: got %b want %b", dut_v, 8'b0100_0000);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(3'b100, 1'b0);
      tests_run++;
      if (walk !== 1'b0 || dut_v !== m_exp()) begin
        tests_failed++;
        $display("FAIL areset_red_held cyc %0d: got %b want %b", i, dut_v, m_exp());
      end
    end
  endtask

  task automatic test_random();
    int ph, left, ill_left, bl;
    logic bv;
    logic [2:0] l;
    bad_codes = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      ph = 2; left = 0; ill_left = 0; bl = 0; bv = 1'b0;
      for (int c = 0; c < 500; c++) begin
        if (ill_left > 0) begin
          l = bad_codes[$urandom_range(4)];
          ill_left--;
        end else if ($urandom_range(199) == 0) begin
          l = bad_codes[$urandom_range(4)];
          ill_left = ($urandom_range(3) == 0) ? 1 : 0;
        end else begin
          if (left == 0) begin
            ph   = (ph + 1) % 3;
            left = int'($urandom_range(1, 10));
          end
          left--;
          l = (ph == 0) ? 3'b010 : (ph == 1) ? 3'b001 : 3'b100;
        end
        if (bl == 0) begin
          bv = 1'($urandom_range(1));
          bl = int'($urandom_range(1, 7));
        end
        bl--;
        step(l, bv);
        tests_run++;
        if (dut_v !== m_exp() || (walk === 1'b1 && dont_walk === 1'b1)) begin
          tests_failed++;
          $display("FAIL random seg %0d cyc %0d: got %b want %b", seg, c, dut_v, m_exp());
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; light_in = 3'b100; btn = 1'b0;
    model_reset();
    test_reset();
    test_request_service();
    test_bounce();
    test_mid_red();
    test_abort();
    test_fault();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ped_walk_ctrl.md
PED_WALK_CTRL -- requirements
Module: ped_walk_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive synchronized-high cycles needed to accept a button press.
REQ-002 Parameter WALK_TIME, default 6: cycles of solid WALK.
REQ-003 Parameter CLEAR_TIME, default 3: cycles of flashing clearance, range 1..15.
REQ-004 Parameter FLASH_DIV, default 1: cycles per dont_walk toggle during clearance.
REQ-005 clk  input  1  rising-edge clock, same domain as the vehicle light controller.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 light_in  input  3  vehicle light code: red=100, green=010, yellow=001, any other value illegal.
REQ-008 btn  input  1  raw pedestrian push-button, asynchronous to clk.
REQ-009 walk  output  1  WALK lamp, registered.
REQ-010 dont_walk  output  1  DONT_WALK lamp, registered.
REQ-011 countdown  output  4  remaining clearance cycles, registered.
REQ-012 req_pending  output  1  latched pedestrian request, registered.
REQ-013 fault  output  1  sticky illegal-light-code indicator, registered.

Function
REQ-014 btn SHALL pass through a 2-flop synchronizer before any use.
REQ-015 The debounced level SHALL go high after DEBOUNCE_CYC consecutive synchronized-high cycles, and SHALL go low on the first synchronized-low cycle.
REQ-016 The rising edge of the debounced level SHALL set req_pending on the next edge, in any state except FAULT.
REQ-017 The design SHALL register light_in every cycle as prev_light.
REQ-018 red_onset SHALL be true when light_in==100 and prev_light!=100.
REQ-019 States SHALL be IDLE, WAIT_RED, WALK, CLEAR and FAULT.
REQ-020 IDLE: walk=0, dont_walk=1; go to WAIT_RED when req_pending=1.
REQ-021 WAIT_RED: walk=0, dont_walk=1; go to WALK on a red_onset edge.
REQ-022 A request raised while light_in is already red SHALL wait for the next red_onset; it SHALL NOT enter WALK mid-red.
REQ-023 Entering WALK SHALL clear req_pending on the same edge.
REQ-024 WALK: walk=1, dont_walk=0 for exactly WALK_TIME cycles, then go to CLEAR.
REQ-025 CLEAR: walk=0; dont_walk=1 on the first CLEAR cycle and toggling every FLASH_DIV cycles after that.
REQ-026 CLEAR countdown SHALL be CLEAR_TIME on the first cycle, decrementing by 1 per cycle down to 1.
REQ-027 CLEAR SHALL then return to IDLE with dont_walk=1 and countdown=0.
REQ-028 countdown SHALL be 0 in every state other than CLEAR.
REQ-029 If light_in!=100 in WALK or CLEAR, the next edge SHALL force IDLE with walk=0, dont_walk=1, countdown=0; it SHALL NOT wait for the timers.
REQ-030 A button press accepted during WALK or CLEAR SHALL set req_pending for service at the next red_onset.
REQ-031 If light_in is illegal on 2 consecutive cycles, the block SHALL enter FAULT from any state.
REQ-032 A single illegal cycle SHALL be ignored.
REQ-033 FAULT: fault=1, walk=0, dont_walk toggling every FLASH_DIV cycles, countdown=0, req_pending=0.
REQ-034 FAULT SHALL be exited only by rst.
REQ-035 The WALK and CLEAR timer SHALL be internal and sized for WALK_TIME+CLEAR_TIME.
REQ-036 The timer SHALL reload on every state entry and SHALL NOT wrap.
REQ-037 walk and dont_walk SHALL never both be 1.

Reset
REQ-038 On rst assertion, all outputs SHALL take reset values immediately, without waiting for clk: walk=0, dont_walk=1, countdown=0, req_pending=0, fault=0.
REQ-039 On rst assertion, the block SHALL clear: state to IDLE, synchronizer and debounce counter to 0, prev_light to 100.
REQ-040 rst asserted during WALK SHALL drop walk within the same cycle.
REQ-041 After rst release the block SHALL resume normally at the first clk edge.
REQ-042 A red light already present when rst is released SHALL NOT produce a red_onset.

Verification
REQ-043 Request service: btn high 10 cycles while green, then light_in goes to red -> req_pending=1 after sync plus 4 cycles; walk=1 for 6 cycles from the red_onset edge; then countdown 3,2,1 with dont_walk 1,0,1; then IDLE, countdown=0.
REQ-044 Bounce: btn high pulses of 3 cycles separated by 1 low cycle, repeated -> req_pending stays 0.
REQ-045 Mid-red request: btn accepted while light_in=100 -> remains WAIT_RED through that red; walk=1 only after green, yellow, then red again.
REQ-046 Early abort: light_in changes to 010 on walk cycle 4 -> next cycle walk=0, dont_walk=1, countdown=0, state IDLE.
REQ-047 Fault: light_in=011 for 1 cycle -> no fault; light_in=110 for 2 cycles -> fault=1, dont_walk flashing; return to legal codes -> fault stays 1 until rst.
REQ-048 Async reset: assert rst between clock edges during WALK -> walk=0 and dont_walk=1 before the next edge; after release, red already present -> no WALK without a new request and a new red_onset.
